// File: rtl/a1339_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module   : a1339_spi_responder
//  Brief    : SPI (mode 3) slave emulating one A1339 angle sensor. Accepts
//             16-bit command frames and returns pipelined 16-bit responses
//             carrying a zero-corrected angle, a programmable offset and a
//             wrap-tracked turn counter.
//  Revision : 1.0 - initial release
// ============================================================================
module a1339_spi_responder #(
    parameter int ANGLE_BITS  = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sck_i,
    input  logic                  ss_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe,
    input  logic [ANGLE_BITS-1:0] angle_i,
    input  logic                  angle_strobe_i,
    output logic [15:0]           turns_o,
    output logic                  frame_done_o
);

    // Register map (7-bit word addresses)
    localparam logic [6:0] ADDR_OFF_LO = 7'h1C;
    localparam logic [6:0] ADDR_OFF_HI = 7'h1D;
    localparam logic [6:0] ADDR_ANGLE  = 7'h20;
    localparam logic [6:0] ADDR_TURNS  = 7'h2C;

    // Field packing helpers
    localparam int HI_BITS   = ANGLE_BITS - 8;   // offset bits held in the high byte
    localparam int ANGLE_PAD = 14 - ANGLE_BITS;  // zeros between status bits and angle
    localparam int WORD_PAD  = 16 - ANGLE_BITS;  // zeros above offset in a word read

    // Wrap-detection thresholds for the signed angle delta
    localparam int                       HALF      = 1 << (ANGLE_BITS - 1);
    localparam logic signed [ANGLE_BITS:0] DELTA_POS = (ANGLE_BITS + 1)'(HALF - 1);
    localparam logic signed [ANGLE_BITS:0] DELTA_NEG = (ANGLE_BITS + 1)'(-HALF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   ss_d;
    logic                   armed;

    logic sck_s;
    logic ss_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;
    logic ss_fall;
    logic ss_rise;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ss_fall  = ~ss_s & ss_d;
    assign ss_rise  = ss_s & ~ss_d;

    // Synchronize SPI pins; ss_n resets "selected" so a frame already in
    // progress at reset release produces no falling edge, and only a
    // genuinely high ss_n arms the next frame start.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_sync  <= '1;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sck_d     <= 1'b1;
            ss_d      <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= (sck_sync << 1)  | SYNC_STAGES'(sck_i);
            ss_sync   <= (ss_sync << 1)   | SYNC_STAGES'(ss_n_i);
            mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(mosi_i);
            sck_d     <= sck_s;
            ss_d      <= ss_s;
            if (ss_s) begin
                armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Angle tracking and turn counting
    // ------------------------------------------------------------------
    // angle_reg doubles as the previous-angle reference: both always hold
    // the last strobed sample.
    logic [ANGLE_BITS-1:0]        angle_reg;
    logic                         seen_valid;
    logic [15:0]                  turns;
    logic signed [ANGLE_BITS:0]   delta;

    assign delta   = $signed({1'b0, angle_i}) - $signed({1'b0, angle_reg});
    assign turns_o = turns;

    // Capture strobed angles and count wraps through zero
    always_ff @(posedge clock) begin
        if (reset) begin
            angle_reg  <= '0;
            seen_valid <= 1'b0;
            turns      <= 16'h0000;
        end else if (angle_strobe_i) begin
            angle_reg  <= angle_i;
            seen_valid <= 1'b1;
            if (seen_valid) begin
                if (delta > DELTA_POS) begin
                    turns <= turns - 16'd1;
                end else if (delta < DELTA_NEG) begin
                    turns <= turns + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command decode (consumed only in EXEC)
    // ------------------------------------------------------------------
    logic [15:0]           rx_shift;
    logic [15:0]           tx_shift;
    logic [15:0]           pending;
    logic [4:0]            bit_cnt;
    logic                  err;
    logic [ANGLE_BITS-1:0] offset;
    state_t                state;

    logic                  cmd_write;
    logic [6:0]            cmd_addr;
    logic [7:0]            cmd_data;
    logic [ANGLE_BITS-1:0] corrected;
    logic [15:0]           exec_resp;
    logic                  exec_err_set;
    logic                  exec_err_clr;
    logic                  wr_off_lo;
    logic                  wr_off_hi;

    assign cmd_write = rx_shift[15];
    assign cmd_addr  = rx_shift[14:8];
    assign cmd_data  = rx_shift[7:0];
    assign corrected = angle_reg - offset;

    // Decode the received command into a response word and register effects
    always_comb begin
        exec_resp    = 16'h0000;
        exec_err_set = 1'b0;
        exec_err_clr = 1'b0;
        wr_off_lo    = 1'b0;
        wr_off_hi    = 1'b0;
        case (cmd_addr)
            ADDR_ANGLE: begin
                if (cmd_write) begin
                    exec_err_set = 1'b1;
                end else begin
                    exec_resp    = {seen_valid, err, {ANGLE_PAD{1'b0}}, corrected};
                    exec_err_clr = 1'b1;
                end
            end
            ADDR_OFF_LO: begin
                if (cmd_write) begin
                    wr_off_lo = 1'b1;
                end else begin
                    exec_resp = {{WORD_PAD{1'b0}}, offset};
                end
            end
            ADDR_OFF_HI: begin
                // Either byte address of the offset reads back the full word
                if (cmd_write) begin
                    wr_off_hi = 1'b1;
                end else begin
                    exec_resp = {{WORD_PAD{1'b0}}, offset};
                end
            end
            ADDR_TURNS: begin
                if (cmd_write) begin
                    exec_err_set = 1'b1;
                end else begin
                    exec_resp = turns;
                end
            end
            default: begin
                exec_err_set = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    // miso only drives data while the output is enabled
    assign miso_o = miso_oe & tx_shift[15];

    // Frame sequencing: shift in/out on sck edges, execute on ss_n release
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= 5'd0;
            rx_shift     <= 16'h0000;
            tx_shift     <= 16'h0000;
            pending      <= 16'h0000;
            err          <= 1'b0;
            offset       <= '0;
            miso_oe      <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    miso_oe <= 1'b0;
                    bit_cnt <= 5'd0;
                    if (ss_fall && armed) begin
                        state    <= ST_SHIFT;
                        tx_shift <= pending;
                        rx_shift <= 16'h0000;
                        miso_oe  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise) begin
                        miso_oe <= 1'b0;
                        if (bit_cnt == 5'd16) begin
                            state        <= ST_EXEC;
                            frame_done_o <= 1'b1;
                        end else begin
                            err   <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else begin
                        if (sck_rise && (bit_cnt != 5'd16)) begin
                            rx_shift <= {rx_shift[14:0], mosi_s};
                            bit_cnt  <= bit_cnt + 5'd1;
                        end
                        // The leading falling edge of mode 3 precedes any
                        // sample, so bit 15 is held until the first rising edge.
                        if (sck_fall && (bit_cnt != 5'd0)) begin
                            tx_shift <= {tx_shift[14:0], 1'b0};
                        end
                    end
                end
                ST_EXEC: begin
                    pending <= exec_resp;
                    if (exec_err_set) begin
                        err <= 1'b1;
                    end else if (exec_err_clr) begin
                        err <= 1'b0;
                    end
                    if (wr_off_lo) begin
                        offset[7:0] <= cmd_data;
                    end
                    if (wr_off_hi) begin
                        offset[ANGLE_BITS-1:8] <= cmd_data[HI_BITS-1:0];
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_a1339_spi_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_a1339_spi_responder
//  Brief    : Self-checking bench for a1339_spi_responder with a frame-level
//             behavioural model of the sensor register file.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_a1339_spi_responder;

    localparam int HALF = 8;   // clocks per sck half period

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sck   = 1'b1;
    logic        ss_n  = 1'b1;
    logic        mosi  = 1'b0;
    logic [11:0] angle = 12'h000;
    logic        strobe = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic [15:0] turns;
    logic        frame_done;

    a1339_spi_responder #(.ANGLE_BITS(12), .SYNC_STAGES(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .sck_i          (sck),
        .ss_n_i         (ss_n),
        .mosi_i         (mosi),
        .miso_o         (miso),
        .miso_oe        (miso_oe),
        .angle_i        (angle),
        .angle_strobe_i (strobe),
        .turns_o        (turns),
        .frame_done_o   (frame_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [15:0] m_turns   = 16'h0;
    logic [11:0] m_angle   = 12'h0;
    bit          m_seen    = 1'b0;
    logic [15:0] m_pending = 16'h0;
    logic [11:0] m_offset  = 12'h0;
    bit          m_err     = 1'b0;
    int          m_frames  = 0;
    int          done_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Shortest-path wrap rule: a jump of more than half a turn is a crossing
    function automatic logic [15:0] turn_step(input int a, input int p, input bit seen);
        int d;
        d = a - p;
        if (!seen)      return 16'h0000;
        if (d > 2047)   return 16'hFFFF;
        if (d < -2048)  return 16'h0001;
        return 16'h0000;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_turns <= 16'h0;
            m_angle <= 12'h0;
            m_seen  <= 1'b0;
        end else if (strobe) begin
            m_angle <= angle;
            m_seen  <= 1'b1;
            m_turns <= m_turns + turn_step(int'(angle), int'(m_angle), m_seen);
        end
    end

    always @(posedge clock) begin
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Continuous comparison of the turn counter against the model
    always @(negedge clock) begin
        check("turns_o", 32'(turns), 32'(m_turns));
    end

    // Apply one completed command to the model
    task automatic model_exec(input logic [15:0] cmd);
        logic [6:0]  addr;
        logic [15:0] resp;
        int          corr;
        addr = cmd[14:8];
        resp = 16'h0000;
        if (cmd[15]) begin
            if (addr == 7'h1C)      m_offset[7:0]  = cmd[7:0];
            else if (addr == 7'h1D) m_offset[11:8] = cmd[3:0];
            else                    m_err = 1'b1;
        end else begin
            case (addr)
                7'h20: begin
                    corr = (int'(m_angle) - int'(m_offset) + 4096) % 4096;
                    resp = {m_seen, m_err, 2'b00, corr[11:0]};
                    m_err = 1'b0;
                end
                7'h1C, 7'h1D: resp = {4'h0, m_offset};
                7'h2C:        resp = m_turns;
                default:      m_err = 1'b1;
            endcase
        end
        m_pending = resp;
        m_frames++;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_miso",       32'(miso),       32'd0);
        check("rst_miso_oe",    32'(miso_oe),    32'd0);
        check("rst_turns",      32'(turns),      32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        reset     = 1'b0;
        m_pending = 16'h0;
        m_offset  = 12'h0;
        m_err     = 1'b0;
    endtask

    task automatic do_strobe(input logic [11:0] a);
        @(negedge clock);
        angle  = a;
        strobe = 1'b1;
        @(negedge clock);
        strobe = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic spi_frame(input logic [15:0] cmd, input int nbits, output logic [15:0] got);
        got = 16'h0;
        @(negedge clock);
        ss_n = 1'b0;
        repeat (HALF) @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            sck  = 1'b0;
            mosi = cmd[15-i];
            repeat (HALF) @(negedge clock);
            got[15-i] = miso;
            sck = 1'b1;
            repeat (HALF) @(negedge clock);
        end
        check("miso_oe_in_frame", 32'(miso_oe), 32'd1);
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (HALF) @(negedge clock);
        check("miso_oe_idle", 32'(miso_oe), 32'd0);
        if (nbits == 16) begin
            check("frame_resp", 32'(got), 32'(m_pending));
            model_exec(cmd);
        end else begin
            m_err = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got;

        // Reset and read ANGLE twice with no strobe
        apply_reset();
        repeat (HALF) @(negedge clock);
        spi_frame(16'h2000, 16, got);  check("first_read",  32'(got), 32'h0000);
        spi_frame(16'h2000, 16, got);  check("second_read", 32'(got), 32'h0000);

        // Offset programming and zero-corrected angle
        do_strobe(12'h123);
        spi_frame(16'h9C23, 16, got);
        spi_frame(16'h9D01, 16, got);
        spi_frame(16'h2000, 16, got);
        spi_frame(16'h2000, 16, got);  check("angle_zeroed", 32'(got), 32'h8000);
        spi_frame(16'h9C00, 16, got);
        spi_frame(16'h9D02, 16, got);
        do_strobe(12'h100);
        spi_frame(16'h2000, 16, got);
        spi_frame(16'h2000, 16, got);  check("angle_wrapped", 32'(got), 32'h8F00);
        spi_frame(16'h1C00, 16, got);
        spi_frame(16'h1D00, 16, got);  check("offset_read", 32'(got), 32'h0200);

        // Turn tracking
        apply_reset();
        repeat (HALF) @(negedge clock);
        do_strobe(12'hFF0);  check("turns_first", 32'(turns), 32'h0000);
        do_strobe(12'h010);  check("turns_up",    32'(turns), 32'h0001);
        do_strobe(12'hFF0);  check("turns_down",  32'(turns), 32'h0000);
        do_strobe(12'h800);  check("turns_half",  32'(turns), 32'h0000);
        spi_frame(16'h2C00, 16, got);
        spi_frame(16'h2C00, 16, got);  check("turns_read0", 32'(got), 32'h0000);
        do_strobe(12'h000);  check("turns_edge",  32'(turns), 32'h0000);
        do_strobe(12'hFFF);  check("turns_neg",   32'(turns), 32'hFFFF);
        spi_frame(16'h2C00, 16, got);
        spi_frame(16'h2C00, 16, got);  check("turns_readm1", 32'(got), 32'hFFFF);

        // Aborted frame sets err, reported once then cleared
        spi_frame(16'h2000, 9, got);
        spi_frame(16'h2000, 16, got);
        spi_frame(16'h2000, 16, got);  check("abort_err_bit", 32'(got[14]), 32'd1);
        spi_frame(16'h2000, 16, got);  check("err_cleared",   32'(got[14]), 32'd0);

        // Write to read-only and unmapped read
        spi_frame(16'hA000, 16, got);
        spi_frame(16'h2000, 16, got);  check("ro_write_resp", 32'(got), 32'h0000);
        spi_frame(16'h0500, 16, got);
        spi_frame(16'h2000, 16, got);  check("unmapped_resp", 32'(got), 32'h0000);

        // Reset in the middle of a write to OFFSET
        @(negedge clock);
        ss_n = 1'b0;
        repeat (HALF) @(negedge clock);
        for (int i = 0; i < 16; i++) begin
            sck  = 1'b0;
            mosi = got[0] ^ 1'b0 ? 1'b0 : (16'h9CAA >> (15 - i)) & 16'h1;
            repeat (HALF) @(negedge clock);
            sck = 1'b1;
            repeat (HALF) @(negedge clock);
            if (i == 7) apply_reset();
        end
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (HALF) @(negedge clock);
        check("mid_reset_oe", 32'(miso_oe), 32'd0);
        spi_frame(16'h1C00, 16, got);  check("mid_reset_r1", 32'(got), 32'h0000);
        spi_frame(16'h1C00, 16, got);  check("mid_reset_r2", 32'(got), 32'h0000);

        repeat (4) @(negedge clock);
        check("frame_done_count", 32'(done_cnt), 32'(m_frames));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/a1339_spi_responder.md
Name: a1339_spi_responder

Overview:
- SPI slave emulating one A1339 angle sensor so the angle-sensor SPI master and the PD/PWM loop can run hardware-in-the-loop against a plant model or a test fixture instead of a magnet.
- Accepts 16-bit command frames, returns pipelined 16-bit responses containing a zero-corrected 12-bit angle, a programmable zero offset and a wrap-tracked turn counter.
- One instance per emulated motor; instances share sck/mosi with their own chip select.

Parameters:
- ANGLE_BITS, 12, width of angle_i, offset and angle field.
- SYNC_STAGES, 2, synchronizer depth on sck_i, ss_n_i and mosi_i.

Ports:
- clock  in  1  system clock; must be at least 8x sck frequency.
- reset  in  1  synchronous, active-high.
- sck_i  in  1  SPI clock, mode 3 (idle high).
- ss_n_i  in  1  active-low chip select.
- mosi_i  in  1  master-out data, MSB first.
- miso_o  out  1  slave-out data, MSB first.
- miso_oe  out  1  tri-state enable; high only while ss_n is low after synchronization.
- angle_i  in  12  raw angle from the plant model.
- angle_strobe_i  in  1  one-cycle pulse; angle_i valid.
- turns_o  out  16  signed turn counter, for the bench and debug.
- frame_done_o  out  1  one-cycle pulse per completed 16-bit frame.

Behaviour:
- Reset sets every output to 0; clears offset, turns, prev_angle, seen_valid and err; clears the bit counter and shift registers; clears the pending response to 0x0000. A reset mid-frame drops the frame, and the remaining sck edges of that frame are ignored until ss_n rises.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized signals, so total input latency is SYNC_STAGES+1 clocks.
- States:
  - IDLE: ss_n high, miso_oe=0, bit counter=0.
  - On an ss_n falling edge, go to SHIFT and load tx_shift with the pending response. miso_o = tx_shift[15].
  - In SHIFT, each sck rising edge shifts mosi into rx_shift and increments bit_cnt (0..16). Each sck falling edge shifts tx_shift left and fills with 0. Falling edges after bit 16 shift zeros.
  - On an ss_n rising edge: if bit_cnt==16, go to EXEC; otherwise set err=1 and return to IDLE with no register change.
  - EXEC lasts one clock: decode cmd, compute the next pending response, pulse frame_done_o, go to IDLE.
- Command format:
  - cmd[15]=0 is a read of the word at addr=cmd[14:8], with cmd[7:0] ignored.
  - cmd[15]=1 writes byte cmd[7:0] to addr.
- Registers:
  - 0x20 ANGLE, read-only. Read data = {seen_valid, err, 2'b00, (angle_reg - offset) mod 4096}.
  - 0x1C OFFSET low byte, read/write. Word read at 0x1C returns {4'h0, offset[11:0]}.
  - 0x1D OFFSET high nibble; a write uses data[3:0].
  - 0x2C TURNS, read-only. Returns turns[15:0].
  - Any other address, or a write to a read-only address, returns 0x0000 and sets err=1.
- Response timing: the response to the frame-N command is shifted out in frame N+1. A write frame's response is 0x0000.
- err handling: err is cleared in the same EXEC cycle that loads an ANGLE response carrying err=1. A new error raised in that frame wins, so err stays set.
- angle_reg, seen_valid and turns update on angle_strobe_i:
  - delta = angle_i - prev_angle as a 13-bit signed value.
  - delta > 2047: turns decrements. delta < -2048: turns increments.
  - The first strobe after reset never changes turns.
  - turns wraps as 16-bit two's complement.
  - prev_angle <= angle_i; seen_valid <= 1.
- A strobe coinciding with EXEC: the response uses angle_reg before the update.
- turns_o = turns, registered.

Test Plan:
- Reset, then read 0x20 twice without a strobe. Frame 1 returns 0x0000; frame 2 returns 0x0000, because seen_valid=0 and angle=0.
- Strobe angle_i=0x123, write 0x1C=0x23, write 0x1D=0x01, read 0x20 twice. The second response is 0x8000 (valid, angle 0). Offset 0x200 with angle 0x100 returns 0x8F00.
- Strobe sequence 0xFF0 -> 0x010 -> 0xFF0 -> 0x800. turns_o goes 0 -> 1 -> 0 -> 0. Reading 0x2C returns 0x0000. Strobes 0x000 then 0xFFF from turns=0 give turns=0xFFFF.
- Abort a frame after 9 sck cycles (ss_n rises), then read 0x20 twice. No register changes; the ANGLE response has bit14=1; the following ANGLE response has bit14=0.
- Write to 0x20, then read 0x20. The write response is 0x0000 and err is set. Reading address 0x05 returns 0x0000.
- Assert reset at bit 7 of a write to 0x1C=0xAA, then read 0x1C twice. The response is 0x0000 and offset stays 0. miso_oe=0 during reset.
